// File: rtl/axi_pattern_frame_writer.sv
// AXI3 write master filling a framebuffer with generated patterns, one burst in flight; wdata is registered
// and valid on the first DATA cycle. Every AW/W/B handshake simply stalls the FSM until the slave responds.
module axi_pattern_frame_writer #(
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = 64,
    parameter int                BURST_LEN       = 16,
    parameter int                FRAME_W         = 1920,
    parameter int                FRAME_H         = 1080,
    parameter logic [ADDR_W-1:0] ADDR_START      = 32'h1000_0000,
    parameter int                FRAMES_PER_STEP = 60
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                enable,
    input  logic [1:0]          pattern_mode,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [3:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awcache,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awqos,
    output logic [3:0]          m_axi_awregion,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic                m_axi_wlast,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic                vsync,
    output logic [15:0]         frames_done,
    output logic                err,
    output logic [1:0]          err_resp,
    output logic                busy
);
    localparam int PPB    = DATA_W / 32;
    localparam int BB     = BURST_LEN * DATA_W / 8;
    localparam int NBURST = FRAME_W * FRAME_H * 4 / BB;
    localparam int BAR_W  = FRAME_W / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic                awvalid_q, wvalid_q, wlast_q, bready_q, vsync_q, err_q;
    logic [1:0]          err_resp_q, mode_q, mode_d;
    logic [15:0]         frames_done_q;
    logic [4:0]          beat_q;
    logic [31:0]         burst_q, fcnt_q, fcnt_d;
    logic [2:0]          step_q, step_d, bar_q, bar_d;
    logic [15:0]         x_q, x_d, y_q, y_d, bpos_q, bpos_d, col;
    logic [31:0]         px;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                beat_fire, last_burst, frame_end, start;

    function automatic logic [31:0] colour(input logic [2:0] c);
        return {8'hFF, {8{c[0]}}, {8{c[2]}}, {8{c[1]}}};
    endfunction

    assign beat_fire  = (state_q == DATA) && wvalid_q && m_axi_wready;
    assign last_burst = (burst_q == 32'(NBURST - 1));
    assign frame_end  = (state_q == RESP) && m_axi_bvalid && last_burst;
    assign start      = ((state_q == IDLE) || frame_end) && enable;

    // Next pixel position and the beat it produces; wdata_q always shows the beat at (x_q, y_q).
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        bar_d   = bar_q;
        bpos_d  = bpos_q;
        fcnt_d  = fcnt_q;
        step_d  = step_q;
        mode_d  = start ? pattern_mode : mode_q;
        wdata_d = '0;
        col     = '0;
        px      = '0;
        if (frame_end) begin
            x_d    = '0;
            y_d    = '0;
            bar_d  = '0;
            bpos_d = '0;
            if (fcnt_q == 32'(FRAMES_PER_STEP - 1)) begin
                fcnt_d = '0;
                step_d = step_q + 3'd1;
            end else begin
                fcnt_d = fcnt_q + 32'd1;
            end
        end else if (beat_fire) begin
            if (x_q + 16'(PPB) == 16'(FRAME_W)) begin
                x_d    = '0;
                y_d    = y_q + 16'd1;
                bar_d  = '0;
                bpos_d = '0;
            end else begin
                x_d = x_q + 16'(PPB);
                if (bpos_q + 16'(PPB) == 16'(BAR_W)) begin
                    bpos_d = '0;
                    bar_d  = bar_q + 3'd1;
                end else begin
                    bpos_d = bpos_q + 16'(PPB);
                end
            end
        end
        for (int k = 0; k < PPB; k++) begin
            col = x_d + 16'(k);
            case (mode_d)
                2'd0:    px = colour(step_d);
                2'd1:    px = colour(bar_d ^ step_d);
                2'd2:    px = {8'hFF, col[7:0], col[7:0], col[7:0]};
                default: px = (col[5] ^ y_d[5]) ? colour(3'd7) : colour(step_d);
            endcase
            wdata_d[32*k +: 32] = px;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            awaddr_q      <= ADDR_START;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            wlast_q       <= 1'b0;
            bready_q      <= 1'b0;
            vsync_q       <= 1'b0;
            err_q         <= 1'b0;
            err_resp_q    <= 2'b00;
            frames_done_q <= '0;
            beat_q        <= '0;
            burst_q       <= '0;
            fcnt_q        <= '0;
            step_q        <= '0;
            mode_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            bar_q         <= '0;
            bpos_q        <= '0;
            wdata_q       <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            bar_q   <= bar_d;
            bpos_q  <= bpos_d;
            fcnt_q  <= fcnt_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            wdata_q <= wdata_d;
            vsync_q <= frame_end;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q   <= ADDR;
                        awvalid_q <= 1'b1;
                    end
                end
                ADDR: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        beat_q    <= '0;
                        wlast_q   <= (BURST_LEN == 1);
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (m_axi_wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= RESP;
                        end else begin
                            beat_q  <= beat_q + 5'd1;
                            wlast_q <= (beat_q == 5'(BURST_LEN - 2));
                        end
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (m_axi_bresp != 2'b00) begin
                            err_q      <= 1'b1;
                            err_resp_q <= m_axi_bresp;
                        end
                        if (last_burst) begin
                            awaddr_q      <= ADDR_START;
                            burst_q       <= '0;
                            frames_done_q <= frames_done_q + 16'd1;
                            state_q       <= enable ? ADDR : IDLE;
                            awvalid_q     <= enable;
                        end else begin
                            awaddr_q  <= awaddr_q + ADDR_W'(BB);
                            burst_q   <= burst_q + 32'd1;
                            state_q   <= ADDR;
                            awvalid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axi_awaddr   = awaddr_q;
    assign m_axi_awlen    = 4'(BURST_LEN - 1);
    assign m_axi_awsize   = 3'($clog2(DATA_W / 8));
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awprot   = 3'b000;
    assign m_axi_awcache  = 4'b0000;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awqos    = 4'b0000;
    assign m_axi_awregion = 4'b0000;
    assign m_axi_awvalid  = awvalid_q;
    assign m_axi_wdata    = wdata_q;
    assign m_axi_wstrb    = '1;
    assign m_axi_wvalid   = wvalid_q;
    assign m_axi_wlast    = wlast_q;
    assign m_axi_bready   = bready_q;
    assign vsync          = vsync_q;
    assign frames_done    = frames_done_q;
    assign err            = err_q;
    assign err_resp       = err_resp_q;
    assign busy           = (state_q != IDLE);
endmodule
